// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential divider.
// State encoding, default width and iteration counter width.
package seq_divider_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int CNT_W = $clog2(DEF_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step.
// Shifts msb into the partial remainder and subtracts if it fits.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             qbit
);

  logic [WIDTH:0] s;

  assign s    = {rem, msb};
  assign qbit = s >= {1'b0, divisor};

  // A fitting difference is below divisor, so the low bits are exact.
  assign rem_next = qbit ? s[WIDTH-1:0] - divisor
                         : s[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring unsigned divider, one quotient bit per clock.
// Start/busy/done handshake; results held until the next completion.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_zero,
  output logic               overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] rem_w;
  logic [WIDTH-1:0] q_w;
  logic [WIDTH-1:0] dvsr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  assign hi = dividend[2*WIDTH-1:WIDTH];
  assign lo = dividend[WIDTH-1:0];

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_w),
    .msb      (q_w[WIDTH-1]),
    .divisor  (dvsr),
    .rem_next (step_rem),
    .qbit     (step_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
      rem_w     <= '0;
      q_w       <= '0;
      dvsr      <= '0;
      cnt       <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (start) begin
            if (divisor == '0) begin
              state     <= DONE;
              done      <= 1'b1;
              quotient  <= '1;
              remainder <= lo;
              div_zero  <= 1'b1;
              overflow  <= 1'b0;
            end else if (hi >= divisor) begin
              // Quotient would need more than WIDTH bits.
              state     <= DONE;
              done      <= 1'b1;
              quotient  <= '1;
              remainder <= '0;
              div_zero  <= 1'b0;
              overflow  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              rem_w <= hi;
              q_w   <= lo;
              dvsr  <= divisor;
              cnt   <= '0;
            end
          end
        end
        RUN: begin
          rem_w <= step_rem;
          q_w   <= {q_w[WIDTH-2:0], step_q};
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= {q_w[WIDTH-2:0], step_q};
            remainder <= step_rem;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider with an arithmetic reference model.
// Directed scenarios plus randomized operations.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        busy;
  logic        done;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        div_zero;
  logic        overflow;

  int errs = 0;
  int checks = 0;

  logic [7:0] pq = '0;
  logic [7:0] pr = '0;
  logic       pdz = 1'b0;
  logic       pov = 1'b0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  function automatic void model(
    input  logic [15:0] dvd,
    input  logic [7:0]  dvs,
    output logic [7:0]  q,
    output logic [7:0]  r,
    output logic        dz,
    output logic        ov
  );
    int n, d;
    n = int'(dvd);
    d = int'(dvs);
    dz = 1'b0;
    ov = 1'b0;
    if (d == 0) begin
      q  = 8'hFF;
      r  = dvd[7:0];
      dz = 1'b1;
    end else if (n / d > 255) begin
      q  = 8'hFF;
      r  = 8'h00;
      ov = 1'b1;
    end else begin
      q = 8'(n / d);
      r = 8'(n % d);
    end
  endfunction

  task automatic launch(input logic [15:0] dvd, input logic [7:0] dvs);
    start    = 1'b1;
    dividend = dvd;
    divisor  = dvs;
  endtask

  // Call right after launch at a negedge; walks the op cycle by cycle.
  task automatic follow(
    input string       name,
    input logic [15:0] dvd,
    input logic [7:0]  dvs,
    input int          pulse,
    input bit          chain,
    input logic [15:0] ndvd,
    input logic [7:0]  ndvs
  );
    logic [7:0] eq, er;
    logic edz, eov, fast, eb;
    int lat;
    model(dvd, dvs, eq, er, edz, eov);
    fast = edz | eov;
    lat = fast ? 1 : 9;
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      eb = !fast && (i < lat);
      checks++;
      if (busy !== eb) begin
        errs++;
        $display("FAIL %s busy c%0d got %b exp %b", name, i, busy, eb);
      end
      checks++;
      if (done !== (i == lat)) begin
        errs++;
        $display("FAIL %s done c%0d got %b exp %b", name, i, done, i == lat);
      end
      if (i < lat) begin
        checks++;
        if ({quotient, remainder, div_zero, overflow} !== {pq, pr, pdz, pov}) begin
          errs++;
          $display("FAIL %s hold c%0d got %h/%h/%b%b exp %h/%h/%b%b", name, i,
                   quotient, remainder, div_zero, overflow, pq, pr, pdz, pov);
        end
      end else begin
        checks++;
        if ({quotient, remainder, div_zero, overflow} !== {eq, er, edz, eov}) begin
          errs++;
          $display("FAIL %s result got q=%h r=%h dz=%b ov=%b exp q=%h r=%h dz=%b ov=%b",
                   name, quotient, remainder, div_zero, overflow, eq, er, edz, eov);
        end
        pq = eq; pr = er; pdz = edz; pov = eov;
      end
      start = (i == pulse);
      if (i == pulse) begin
        dividend = 16'd50;
        divisor  = 8'd5;
      end
      if (chain && i == lat) launch(ndvd, ndvs);
    end
  endtask

  task automatic op(input string name, input logic [15:0] dvd, input logic [7:0] dvs);
    @(negedge clk);
    launch(dvd, dvs);
    follow(name, dvd, dvs, 0, 1'b0, 16'd0, 8'd0);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, done, quotient, remainder, div_zero, overflow} !== 20'd0) begin
      errs++;
      $display("FAIL reset_state got %b%b %h %h %b%b exp all zero",
               busy, done, quotient, remainder, div_zero, overflow);
    end
  endtask

  task automatic test_directed();
    op("d1000_7", 16'd1000, 8'd7);
    op("dFE01_FF", 16'hFE01, 8'hFF);
    op("ovf_FFFF", 16'hFFFF, 8'hFF);
    op("dzero", 16'h1234, 8'd0);
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errs++;
      $display("FAIL done_single got %b exp 0", done);
    end
  endtask

  task automatic test_ignore();
    @(negedge clk);
    launch(16'd100, 8'd3);
    follow("ignore", 16'd100, 8'd3, 4, 1'b0, 16'd0, 8'd0);
  endtask

  task automatic test_abort();
    int seen;
    @(negedge clk);
    launch(16'd200, 8'd9);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, done, quotient, remainder, div_zero, overflow} !== 20'd0) begin
      errs++;
      $display("FAIL abort_clear got %b%b %h %h %b%b exp all zero",
               busy, done, quotient, remainder, div_zero, overflow);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      errs++;
      $display("FAIL abort_quiet got %0d active cycles exp 0", seen);
    end
    pq = '0; pr = '0; pdz = 1'b0; pov = 1'b0;
    op("after_abort", 16'd200, 8'd9);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    launch(16'd255, 8'd16);
    follow("b2b_first", 16'd255, 8'd16, 0, 1'b1, 16'd65535, 8'd255);
    follow("b2b_second", 16'd65535, 8'd255, 0, 1'b0, 16'd0, 8'd0);
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errs++;
      $display("FAIL b2b_end done got %b exp 0", done);
    end
  endtask

  task automatic test_random();
    logic [15:0] dvd;
    logic [7:0] dvs;
    for (int k = 0; k < 40; k++) begin
      dvs = 8'($urandom_range(0, 255));
      dvd = 16'($urandom);
      if (dvs != 0 && $urandom_range(0, 9) < 8)
        dvd[15:8] = 8'($urandom_range(0, int'(dvs) - 1));
      op("random", dvd, dvs);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore();
    test_abort();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle restoring unsigned divider for the calculator datapath; the inverse operation of the 8x8 combinational multiplier.
- Divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor and produces a WIDTH-bit quotient and a WIDTH-bit remainder.
- Retires one quotient bit per clock, under a start/busy/done handshake from the ALU control FSM.

Parameters:
WIDTH, 8, divisor/quotient/remainder width; dividend is 2*WIDTH bits

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
dividend  input  2*WIDTH  numerator, captured on accepted start
divisor  input  WIDTH  denominator, captured on accepted start
busy  output  1  iteration in progress
done  output  1  one-cycle pulse: result valid and flags updated
quotient  output  WIDTH  result quotient, held until next completion
remainder  output  WIDTH  result remainder, held until next completion
div_zero  output  1  last result was divide-by-zero
overflow  output  1  last result had a quotient that did not fit WIDTH bits

Behaviour:
- Reset: one clock, synchronous, active-high. State goes to IDLE. busy, done, quotient, remainder, div_zero and overflow all reset to 0. Iteration counter resets to 0.
- All outputs are registered.
- FSM states:
  - IDLE: start=1 is accepted.
  - RUN: iterating.
  - DONE: lasts one cycle with done=1; start=1 is also accepted here, giving back-to-back operation.
- Accepted start, checks in priority order:
  - divisor==0: go to DONE next cycle. quotient=all-ones, remainder=dividend[WIDTH-1:0], div_zero=1, overflow=0.
  - else dividend[2W-1:W] >= divisor: go to DONE next cycle. quotient=all-ones, remainder=0, overflow=1, div_zero=0.
  - else: load working rem=dividend[2W-1:W] and working q=dividend[W-1:0], clear the counter, go to RUN.
- RUN iteration, once per cycle:
  - s = {rem, q[W-1]}, WIDTH+1 bits.
  - If s >= divisor: rem = (s - divisor)[W-1:0] and qbit = 1.
  - Else: rem = s[W-1:0] and qbit = 0.
  - q = {q[W-2:0], qbit}.
  - Counter increments each iteration. After iteration WIDTH, go to DONE and copy q and rem to quotient and remainder. Both flags are cleared.
- Latency, with the start-sampled cycle as cycle 0:
  - Normal case: busy=1 in cycles 1..WIDTH, done=1 in cycle WIDTH+1 (cycle 9 for WIDTH=8).
  - Divide-by-zero or overflow: done=1 in cycle 1; busy never asserts.
- busy=1 exactly in RUN. start is ignored while busy=1, and dividend/divisor changes during RUN have no effect because the divisor is captured.
- quotient, remainder, div_zero and overflow change only on the edge that enters DONE. They are stable at all other times, including during a following RUN.
- done is never asserted for two consecutive cycles unless a back-to-back start hits the divide-by-zero or overflow path.
- Reset during RUN aborts the operation: no done pulse, outputs cleared to 0.
- Reset has priority over start in the same cycle.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, RUN, DONE);
  - the default WIDTH constant;
  - the counter width, clog2(WIDTH+1).
- Sub-module div_step: purely combinational restoring step. Inputs rem, msb-in, divisor; outputs next rem and qbit. It is instantiated once and reused every cycle.

Test Plan:
- dividend=16'd1000, divisor=8'd7 -> done in cycle 9; quotient=8'd142, remainder=8'd6, flags 0; busy high for cycles 1-8 exactly.
- dividend=16'hFE01, divisor=8'hFF -> quotient=8'hFF, remainder=8'h00, overflow=0. Then dividend=16'hFFFF, divisor=8'hFF -> done in cycle 1, overflow=1, quotient=8'hFF, remainder=0.
- divisor=0, dividend=16'h1234 -> done in cycle 1; div_zero=1, quotient=8'hFF, remainder=8'h34.
- Start 100/3, then pulse start with 50/5 in cycle 4 -> the second start is ignored; result quotient=33, remainder=1 in cycle 9.
- Start 200/9, assert reset in cycle 5 -> no done pulse; all outputs read 0 from the cycle after reset. A new start then completes normally.
- Back-to-back: 255/16, with start held during the DONE cycle for 65535/255 -> first result 15 r 15. Second is an overflow, so done is also high in the following cycle (two consecutive done cycles), with overflow=1.
